// File: rtl/filt_rbuf.sv
// rtl/filt_rbuf.sv - capture ring buffer with level/slope trigger and pre-trigger depth
// Optional forced-trigger timeout enabled by defining AUTO_TRIG_EN.
module filt_rbuf #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int RBUF_ADDR_SIZE = 10,
    parameter int PRETRIG        = 256,
    parameter int AUTO_TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      filt_done,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    input  logic                      arm,
    input  logic [XADC_DATA_SIZE-1:0] trig_level,
    input  logic                      trig_slope,
    input  logic [RBUF_ADDR_SIZE-1:0] rd_addr,
    output logic [XADC_DATA_SIZE-1:0] rd_data,
    output logic [RBUF_ADDR_SIZE-1:0] trig_addr,
    output logic                      rbuf_busy,
    output logic                      rbuf_done,
    output logic                      trig_auto
);

    localparam int W     = XADC_DATA_SIZE;
    localparam int A     = RBUF_ADDR_SIZE;
    localparam int DEPTH = 1 << A;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [A:0]   PRE_CNT    = (A+1)'(PRETRIG);
    localparam logic [A:0]   POST_CNT   = (A+1)'(DEPTH - PRETRIG);
    localparam logic [A-1:0] PRE_OFF    = A'(PRETRIG);
    localparam state_t       ARM_STATE  = (PRETRIG == 0) ? S_ARMED : S_PRE;
    localparam state_t       TRIG_STATE = (DEPTH - PRETRIG == 1) ? S_DONE : S_POST;

    logic [W-1:0] mem [DEPTH];

    state_t       state, state_n;
    logic         done_q;
    logic [A-1:0] wr_ptr;
    logic [A:0]   cnt;
    logic [A:0]   cnt_inc;
    logic [W-1:0] prev;
    logic         prev_valid;
    logic         sample_ev;
    logic         capturing;
    logic         wr_en;
    logic         real_trig;
    logic         auto_fire;
    logic         trig_hit;
    logic         busy_c;
    logic         done_c;
    logic [A-1:0] rd_phys;

    assign sample_ev = done_q & ~filt_done;
    assign capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    // arm has priority: a sample arriving with arm is dropped
    assign wr_en     = sample_ev & ~arm & capturing;
    assign cnt_inc   = cnt + 1'b1;
    assign rd_phys   = trig_addr - PRE_OFF + rd_addr;

    always_comb begin
        real_trig = 1'b0;
        if (prev_valid) begin
            if (trig_slope)
                real_trig = (prev > trig_level) && (filt_result <= trig_level);
            else
                real_trig = (prev < trig_level) && (filt_result >= trig_level);
        end
    end

`ifdef AUTO_TRIG_EN
    localparam int CW = $clog2(AUTO_TIMEOUT + 1);
    logic [CW-1:0] auto_cnt;

    assign auto_fire = (auto_cnt == CW'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt  <= '0;
            trig_auto <= 1'b0;
        end else if (arm) begin
            auto_cnt  <= '0;
            trig_auto <= 1'b0;
        end else if (wr_en && state == S_ARMED) begin
            if (trig_hit) begin
                auto_cnt  <= '0;
                trig_auto <= ~real_trig;
            end else begin
                auto_cnt  <= auto_cnt + 1'b1;
            end
        end
    end
`else
    assign auto_fire = 1'b0;
    assign trig_auto = 1'b0;
`endif

    assign trig_hit = wr_en && (state == S_ARMED) && (real_trig || auto_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (arm) begin
            state_n = ARM_STATE;
        end else if (wr_en) begin
            case (state)
                S_PRE:   if (cnt_inc == PRE_CNT) state_n = S_ARMED;
                S_ARMED: if (trig_hit) state_n = TRIG_STATE;
                S_POST:  if (cnt_inc == POST_CNT) state_n = S_DONE;
                default: state_n = state;
            endcase
        end
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            S_PRE, S_ARMED, S_POST: busy_c = 1'b1;
            S_DONE:                 done_c = 1'b1;
            default:                busy_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_addr  <= '0;
            rbuf_busy  <= 1'b0;
            rbuf_done  <= 1'b0;
            rd_data    <= '0;
        end else begin
            done_q    <= filt_done;
            rbuf_busy <= busy_c;
            rbuf_done <= done_c;
            rd_data   <= mem[rd_phys];
            if (arm) begin
                wr_ptr     <= '0;
                cnt        <= '0;
                prev_valid <= 1'b0;
            end else if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev       <= filt_result;
                prev_valid <= 1'b1;
                // the trigger sample is post-trigger sample number one
                if (trig_hit) begin
                    trig_addr <= wr_ptr;
                    cnt       <= (A+1)'(1);
                end else if (state != S_ARMED) begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= filt_result;
    end

endmodule

// File: tb/tb_filt_rbuf.sv
// tb/tb_filt_rbuf.sv - directed table-driven bench for filt_rbuf (DEPTH 16, PRETRIG 4)
module tb_filt_rbuf;

    logic        clk;
    logic        rst_n;
    logic        filt_done;
    logic [15:0] filt_result;
    logic        arm;
    logic [15:0] trig_level;
    logic        trig_slope;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  trig_addr;
    logic        rbuf_busy;
    logic        rbuf_done;
    logic        trig_auto;

    int n_cmp  = 0;
    int n_fail = 0;

    filt_rbuf #(
        .XADC_DATA_SIZE(16),
        .RBUF_ADDR_SIZE(4),
        .PRETRIG       (4),
        .AUTO_TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .filt_done  (filt_done),
        .filt_result(filt_result),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .trig_addr  (trig_addr),
        .rbuf_busy  (rbuf_busy),
        .rbuf_done  (rbuf_done),
        .trig_auto  (trig_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] start;
        logic [15:0] step;
        logic [15:0] level;
        logic        slope;
        int          nsamp;
        logic [3:0]  exp_trig;
    } ramp_t;

    ramp_t rows [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_sample(input logic [15:0] v);
        @(negedge clk);
        filt_result = v;
        filt_done   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        filt_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        arm       = 1'b0;
        filt_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, {16'd0, rd_data}, {16'd0, exp});
    endtask

    task automatic ramp(input logic [15:0] start, input logic [15:0] step, input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = start + step * 16'(i);
            send_sample(v);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rd_data"},   {16'd0, rd_data},   32'd0);
        chk({name, "_trig_addr"}, {28'd0, trig_addr}, 32'd0);
        chk({name, "_busy"},      {31'd0, rbuf_busy}, 32'd0);
        chk({name, "_done"},      {31'd0, rbuf_done}, 32'd0);
        chk({name, "_auto"},      {31'd0, trig_auto}, 32'd0);
    endtask

    initial begin
        logic [15:0] seq3 [7];
        logic [15:0] v;
        int          idx;

        rst_n = 1'b0; filt_done = 1'b0; filt_result = '0; arm = 1'b0;
        trig_level = '0; trig_slope = 1'b0; rd_addr = '0;

        rows[0] = '{16'd0,   16'd10,    16'd55, 1'b0, 18, 4'd6};
        rows[1] = '{16'd100, 16'hFFF6,  16'd55, 1'b1, 17, 4'd5};
        rows[2] = '{16'd0,   16'd1,     16'd5,  1'b0, 17, 4'd5};
        rows[3] = '{16'd100, 16'hFFFB,  16'd55, 1'b1, 21, 4'd9};

        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        ramp(16'd7, 16'd3, 10);
        chk("idle_done", {31'd0, rbuf_done}, 32'd0);
        chk("idle_busy", {31'd0, rbuf_busy}, 32'd0);

        // ramp scenarios from the table
        for (int r = 0; r < 4; r++) begin
            do_reset();
            trig_level = rows[r].level;
            trig_slope = rows[r].slope;
            pulse_arm();
            ramp(rows[r].start, rows[r].step, rows[r].nsamp - 1);
            chk($sformatf("row%0d_busy_pre", r), {31'd0, rbuf_busy}, 32'd1);
            chk($sformatf("row%0d_done_pre", r), {31'd0, rbuf_done}, 32'd0);
            v = rows[r].start + rows[r].step * 16'(rows[r].nsamp - 1);
            send_sample(v);
            chk($sformatf("row%0d_done", r), {31'd0, rbuf_done}, 32'd1);
            chk($sformatf("row%0d_busy", r), {31'd0, rbuf_busy}, 32'd0);
            chk($sformatf("row%0d_trig_addr", r), {28'd0, trig_addr}, {28'd0, rows[r].exp_trig});
            chk($sformatf("row%0d_auto", r), {31'd0, trig_auto}, 32'd0);
            for (int i = 0; i < 16; i++) begin
                idx = int'(rows[r].exp_trig) - 4 + i;
                v   = rows[r].start + rows[r].step * 16'(idx);
                read_chk($sformatf("row%0d_rd%0d", r, i), 4'(i), v);
            end
        end

        // trigger masked during PRE
        do_reset();
        seq3 = '{16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd0, 16'd100};
        trig_level = 16'd50;
        trig_slope = 1'b0;
        pulse_arm();
        for (int i = 0; i < 6; i++) send_sample(seq3[i]);
        chk("pre_mask_trig_addr", {28'd0, trig_addr}, 32'd0);
        send_sample(seq3[6]);
        chk("pre_mask_trig_addr6", {28'd0, trig_addr}, 32'd6);
        ramp(16'd200, 16'd0, 10);
        chk("pre_mask_done_early", {31'd0, rbuf_done}, 32'd0);
        send_sample(16'd200);
        chk("pre_mask_done", {31'd0, rbuf_done}, 32'd1);
        read_chk("pre_mask_rd_trig", 4'd4, 16'd100);
        read_chk("pre_mask_rd_prev", 4'd3, 16'd0);

        // arm during POST restarts from address 0
        do_reset();
        trig_level = 16'd55;
        trig_slope = 1'b0;
        pulse_arm();
        ramp(16'd0, 16'd10, 9);
        pulse_arm();
        @(negedge clk);
        chk("rearm_done", {31'd0, rbuf_done}, 32'd0);
        chk("rearm_busy", {31'd0, rbuf_busy}, 32'd1);
        ramp(16'd0, 16'd10, 18);
        chk("rearm_trig_addr", {28'd0, trig_addr}, 32'd6);
        chk("rearm_done_end", {31'd0, rbuf_done}, 32'd1);
        read_chk("rearm_rd0", 4'd0, 16'd20);

        // reset pulse mid-POST
        pulse_arm();
        ramp(16'd0, 16'd10, 9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_post");
        @(negedge clk);
        rst_n = 1'b1;
        ramp(16'd0, 16'd10, 3);
        chk("rst_post_idle_busy", {31'd0, rbuf_busy}, 32'd0);

        // arm coincident with a sample event drops that sample
        @(negedge clk);
        filt_result = 16'd999;
        filt_done   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        filt_done = 1'b0;
        arm       = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        ramp(16'd0, 16'd10, 18);
        chk("arm_ev_trig_addr", {28'd0, trig_addr}, 32'd6);
        chk("arm_ev_done", {31'd0, rbuf_done}, 32'd1);
        read_chk("arm_ev_rd0", 4'd0, 16'd20);

        // constant stream: forced trigger only with the timeout built in
        do_reset();
        trig_level = 16'd55;
        trig_slope = 1'b0;
        pulse_arm();
        ramp(16'd0, 16'd0, 11);
        chk("auto_before", {31'd0, trig_auto}, 32'd0);
        send_sample(16'd0);
`ifdef AUTO_TRIG_EN
        chk("auto_flag", {31'd0, trig_auto}, 32'd1);
        chk("auto_trig_addr", {28'd0, trig_addr}, 32'd11);
        ramp(16'd0, 16'd0, 10);
        chk("auto_done_early", {31'd0, rbuf_done}, 32'd0);
        send_sample(16'd0);
        chk("auto_done", {31'd0, rbuf_done}, 32'd1);
`else
        ramp(16'd0, 16'd0, 20);
        chk("noauto_flag", {31'd0, trig_auto}, 32'd0);
        chk("noauto_busy", {31'd0, rbuf_busy}, 32'd1);
        chk("noauto_done", {31'd0, rbuf_done}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
